brick_game_ctrl: RTL and testbench
==================================

Name: brick_game_ctrl

Overview:
Game-level controller for the brick field.
- Sequences idle/serve/play/lose/win phases.
- Tracks per-brick alive state and remaining lives.
- Funnels brick collision events through a round-robin arbiter into a single saturating score accumulator. Simultaneous hits are queued, never dropped.
- Sits between the per-brick collision detectors and the ball/paddle logic and score display.

Parameters:
NUM_BLOCKS, 15, number of bricks; collision/alive vector width
LIVES, 3, lives loaded at game start (1..3)
POINTS, 10, score added per brick cleared
SCORE_W, 8, score width
SERVE_DELAY, 60, cycles spent in SERVE before ball release (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  level-sensitive start button; only its rising edge acts
ball_lost  in  1  one-cycle pulse, ball passed the paddle
collide  in  NUM_BLOCKS  per-brick collision level, bit i = brick i
block_alive  out  NUM_BLOCKS  1 = brick i drawn and collidable
score  out  SCORE_W  current score
lives  out  2  remaining lives
ball_en  out  1  ball motion enable
serve_rst  out  1  holds ball/paddle at serve position
game_over  out  1  high in OVER state
win  out  1  high in WIN state

Behaviour:
- Reset (rst=0, async): state=IDLE, block_alive=all ones, score=0, lives=LIVES, pending=0, rr_ptr=0, serve counter=0, edge registers=0.
- Edge detect: registered copies of start and collide. start_rise = start & ~start_q. hit_rise[i] = collide[i] & ~collide_q[i]. Edge registers update every cycle in every state.
- Pending mask: pending[i] sets when hit_rise[i] & block_alive[i] & state==PLAY. Sets only on a rising edge, so one brick scores at most once.
- Arbiter:
  - Active only in PLAY. Each cycle it grants one pending bit: the lowest index >= rr_ptr, wrapping to 0.
  - On grant g: pending[g] cleared, block_alive[g] cleared, score += POINTS, rr_ptr <= (g+1) mod NUM_BLOCKS.
  - Latency: collide rise at cycle N -> pending at N+1 -> earliest score/alive update visible at N+2.
  - A set and a grant on the same bit in the same cycle never occurs: set requires the bit to be alive and not already pending.
- Score arithmetic: saturating. If score + POINTS > 2^SCORE_W-1, score = 2^SCORE_W-1.
- FSM:
  - IDLE: ball_en=0, serve_rst=1. On start_rise -> SERVE.
  - SERVE: ball_en=0, serve_rst=1. The counter counts 0..SERVE_DELAY-1; on the terminal count -> PLAY and the counter clears. Total serve time is SERVE_DELAY cycles.
  - PLAY: ball_en=1, serve_rst=0. Checked in priority order:
    1. ball_lost: if lives==1 then lives=0 -> OVER; else lives-1 -> SERVE. Pending bits are kept and resume draining on the next PLAY.
    2. block_alive==0 and pending==0 -> WIN.
  - OVER: game_over=1, ball_en=0, serve_rst=1.
  - WIN: win=1, ball_en=0, serve_rst=1.
  - From OVER or WIN, start_rise reloads: score=0, lives=LIVES, block_alive=all ones, pending=0, rr_ptr=0, then -> SERVE.
- Boundaries:
  - ball_lost outside PLAY is ignored.
  - start_rise in SERVE/PLAY is ignored.
  - A ball_lost pulse in the same cycle as the final grant: the grant is applied (score updated) and the life is lost. WIN is evaluated only on a later PLAY cycle with no ball_lost.
  - Collisions on dead bricks are ignored.
  - Reset mid-game aborts immediately to the reset values.

Test Plan:
- Reset, start rise, wait -> serve_rst=1 for exactly 60 cycles, then ball_en=1, state PLAY, lives=3, score=0.
- In PLAY, collide[3:0]=4'b1111 in one cycle -> 4 consecutive grants in order 0,1,2,3; score reads 10,20,30,40 on successive cycles; block_alive[3:0]=0.
- Hold collide[5]=1 for 20 cycles, drop, then re-raise -> score +10 once only; brick 5 dead, so re-raise is ignored.
- Three ball_lost pulses, each separated by a full SERVE -> lives 2,1,0; game_over=1; ball_en=0. A further start rise -> lives=3, score=0, all bricks alive, SERVE.
- Clear all 15 bricks -> score=150, win=1 one cycle after the last grant. With POINTS=20, 15 bricks -> score saturates at 255.
- Assert rst=0 mid-PLAY with pending bits set -> all outputs take reset values asynchronously; pending cleared; state IDLE.

Source files
------------

// File: rtl/brick_game_ctrl.sv
// Game-level controller for the brick field.
// Sequences the IDLE/SERVE/PLAY/OVER/WIN phases, tracks per-brick alive state
// and remaining lives, and funnels brick hits through a round-robin arbiter
// into one saturating score accumulator.
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-low reset
//   start        start button level; only its rising edge acts
//   ball_lost    one-cycle pulse, ball passed the paddle
//   collide      per-brick collision level
//   block_alive  1 = brick drawn and collidable
//   score        current score (saturating)
//   lives        remaining lives
//   ball_en      ball motion enable (PLAY)
//   serve_rst    holds ball/paddle at serve position (not PLAY)
//   game_over    high in OVER
//   win          high in WIN
module brick_game_ctrl #(
  parameter int unsigned NUM_BLOCKS  = 15,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned POINTS      = 10,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ball_lost,
  input  logic [NUM_BLOCKS-1:0] collide,
  output logic [NUM_BLOCKS-1:0] block_alive,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            lives,
  output logic                  ball_en,
  output logic                  serve_rst,
  output logic                  game_over,
  output logic                  win
);

  localparam int unsigned PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_BLOCKS - 1);
  localparam logic [SCORE_W:0]   SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0]   PTS       = (SCORE_W + 1)'(POINTS);

  logic [2:0]            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_BLOCKS-1:0] pending, pending_nxt;
  logic [NUM_BLOCKS-1:0] alive_nxt;
  logic [SCORE_W-1:0]    score_nxt;
  logic [1:0]            lives_nxt;
  logic [PTR_W-1:0]      rr_ptr, rr_nxt;
  logic                  start_q;
  logic [NUM_BLOCKS-1:0] collide_q;
  logic                  ball_en_nxt, serve_rst_nxt, game_over_nxt, win_nxt;

  logic                  start_rise;
  logic [NUM_BLOCKS-1:0] hit_rise;
  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_BLOCKS-1:0] grant_mask;
  logic [SCORE_W:0]      score_sum;
  logic [SCORE_W-1:0]    score_add;

  assign start_rise = start & ~start_q;
  assign hit_rise   = collide & ~collide_q;
  assign grant_mask = grant_vld ? (NUM_BLOCKS'(1) << grant_idx) : '0;
  assign score_sum  = {1'b0, score} + PTS;
  assign score_add  = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];

  // Round-robin pick: first pending index at or after rr_ptr, wrapping.
  always_comb begin
    int idx_w;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_w     = 0;
    for (int k = 0; k < int'(NUM_BLOCKS); k++) begin
      idx_w = (int'(rr_ptr) + k) % int'(NUM_BLOCKS);
      if (!grant_vld && pending[PTR_W'(idx_w)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx_w);
      end
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    alive_nxt   = block_alive;
    score_nxt   = score;
    lives_nxt   = lives;
    rr_nxt      = rr_ptr;
    case (state)
      S_IDLE: if (start_rise) state_nxt = S_SERVE;
      S_SERVE: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_PLAY;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_PLAY: begin
        // A bit only sets when alive and not pending, so it never collides with its own grant.
        pending_nxt = (pending & ~grant_mask) | (hit_rise & block_alive & ~pending);
        if (grant_vld) begin
          alive_nxt = block_alive & ~grant_mask;
          score_nxt = score_add;
          rr_nxt    = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
        end
        // Lost ball outranks the win check; pending hits survive into the next PLAY.
        if (ball_lost) begin
          if (lives == 2'd1) begin
            lives_nxt = 2'd0;
            state_nxt = S_OVER;
          end else begin
            lives_nxt = lives - 2'd1;
            state_nxt = S_SERVE;
          end
        end else if (block_alive == '0 && pending == '0) begin
          state_nxt = S_WIN;
        end
      end
      S_OVER, S_WIN: begin
        if (start_rise) begin
          score_nxt   = '0;
          lives_nxt   = 2'(LIVES);
          alive_nxt   = '1;
          pending_nxt = '0;
          rr_nxt      = '0;
          state_nxt   = S_SERVE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    ball_en_nxt   = (state_nxt == S_PLAY);
    serve_rst_nxt = (state_nxt != S_PLAY);
    game_over_nxt = (state_nxt == S_OVER);
    win_nxt       = (state_nxt == S_WIN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pending     <= '0;
      block_alive <= '1;
      score       <= '0;
      lives       <= 2'(LIVES);
      rr_ptr      <= '0;
      start_q     <= 1'b0;
      collide_q   <= '0;
      ball_en     <= 1'b0;
      serve_rst   <= 1'b1;
      game_over   <= 1'b0;
      win         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pending     <= pending_nxt;
      block_alive <= alive_nxt;
      score       <= score_nxt;
      lives       <= lives_nxt;
      rr_ptr      <= rr_nxt;
      start_q     <= start;
      collide_q   <= collide;
      ball_en     <= ball_en_nxt;
      serve_rst   <= serve_rst_nxt;
      game_over   <= game_over_nxt;
      win         <= win_nxt;
    end
  end

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Self-checking bench for brick_game_ctrl: constant-vector table, directed
// multi-cycle sequences and random play against a behavioural game model.
module tb_brick_game_ctrl;

  localparam int N = 15;

  logic          clk = 1'b0;
  logic          rst, start, ball_lost;
  logic [N-1:0]  collide;
  logic [N-1:0]  block_alive, alive2;
  logic [7:0]    score, score2;
  logic [1:0]    lives, lives2;
  logic          ball_en, serve_rst, game_over, win;
  logic          ball_en2, serve_rst2, game_over2, win2;

  always #5 clk = ~clk;

  brick_game_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ball_lost(ball_lost), .collide(collide),
    .block_alive(block_alive), .score(score), .lives(lives), .ball_en(ball_en),
    .serve_rst(serve_rst), .game_over(game_over), .win(win)
  );

  brick_game_ctrl #(.POINTS(20)) dut2 (
    .clk(clk), .rst(rst), .start(start), .ball_lost(ball_lost), .collide(collide),
    .block_alive(alive2), .score(score2), .lives(lives2), .ball_en(ball_en2),
    .serve_rst(serve_rst2), .game_over(game_over2), .win(win2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural game model
  localparam int MI = 0, MS = 1, MP = 2, MO = 3, MW = 4;
  int       m_state, m_cnt, m_rr, m_score, m_score2, m_lives;
  bit [N-1:0] m_alive, m_pend, m_coll_q;
  bit       m_start_q;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void m_reset();
    m_state = MI; m_cnt = 0; m_rr = 0; m_score = 0; m_score2 = 0; m_lives = 3;
    m_alive = '1; m_pend = '0; m_coll_q = '0; m_start_q = 1'b0;
  endfunction

  function automatic void m_step();
    bit         sr;
    bit [N-1:0] hit, old_alive, old_pend, newly;
    int         g;
    sr  = start & ~m_start_q;
    hit = collide & ~m_coll_q;
    old_alive = m_alive;
    old_pend  = m_pend;
    g = -1;
    case (m_state)
      MI: if (sr) m_state = MS;
      MS: begin
        m_cnt++;
        if (m_cnt == 60) begin m_cnt = 0; m_state = MP; end
      end
      MP: begin
        for (int k = 0; k < N; k++)
          if (g < 0 && old_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        newly = hit & old_alive & ~old_pend;
        if (g >= 0) begin
          m_pend[g]  = 1'b0;
          m_alive[g] = 1'b0;
          m_score    = sat(m_score + 10);
          m_score2   = sat(m_score2 + 20);
          m_rr       = (g + 1) % N;
        end
        m_pend = m_pend | newly;
        if (ball_lost) begin
          m_lives--;
          m_state = (m_lives == 0) ? MO : MS;
        end else if (old_alive == 0 && old_pend == 0) begin
          m_state = MW;
        end
      end
      default: begin
        if (sr) begin
          m_score = 0; m_score2 = 0; m_lives = 3; m_alive = '1; m_pend = '0; m_rr = 0;
          m_state = MS;
        end
      end
    endcase
    m_start_q = start;
    m_coll_q  = collide;
  endfunction

  task automatic do_check();
    chk("alive", 32'(block_alive), 32'(m_alive));
    chk("score", 32'(score), 32'(m_score));
    chk("score_p20", 32'(score2), 32'(m_score2));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("ball_en", 32'(ball_en), 32'(m_state == MP));
    chk("serve_rst", 32'(serve_rst), 32'(m_state != MP));
    chk("game_over", 32'(game_over), 32'(m_state == MO));
    chk("win", 32'(win), 32'(m_state == MW));
  endtask

  // One clock: model advances with the DUT, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) m_step();
    #1;
    do_check();
  endtask

  task automatic wait_play();
    for (int i = 0; i < 100 && !ball_en; i++) cycle();
    chk("wait_play", 32'(ball_en), 32'd1);
  endtask

  typedef struct {
    logic [N-1:0] coll;
    int           exp_score;
    logic [N-1:0] exp_alive;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{15'h000F, 0,  15'h7FFF};
    tbl[1]  = '{15'h000F, 10, 15'h7FFE};
    tbl[2]  = '{15'h0000, 20, 15'h7FFC};
    tbl[3]  = '{15'h0000, 30, 15'h7FF8};
    tbl[4]  = '{15'h0000, 40, 15'h7FF0};
    tbl[5]  = '{15'h0020, 40, 15'h7FF0};
    tbl[6]  = '{15'h0020, 50, 15'h7FD0};
    tbl[7]  = '{15'h0020, 50, 15'h7FD0};
    tbl[8]  = '{15'h0000, 50, 15'h7FD0};
    tbl[9]  = '{15'h0020, 50, 15'h7FD0};
    tbl[10] = '{15'h0000, 50, 15'h7FD0};

    rst = 1'b0; start = 1'b0; ball_lost = 1'b0; collide = '0;
    m_reset();
    #2;
    repeat (3) cycle();
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_alive", 32'(block_alive), 32'h7FFF);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_serve_rst", 32'(serve_rst), 32'd1);
    chk("rst_ball_en", 32'(ball_en), 32'd0);

    // Serve lasts exactly 60 cycles after the start edge
    rst = 1'b1;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !ball_en; i++) begin
      if (serve_rst) n++;
      cycle();
    end
    chk("serve_len", 32'(n), 32'd60);
    chk("play_lives", 32'(lives), 32'd3);
    chk("play_score", 32'(score), 32'd0);

    // Simultaneous hits drain in order; held and re-raised hit scores once
    for (int i = 0; i < 11; i++) begin
      collide = tbl[i].coll;
      cycle();
      chk("tbl_score", 32'(score), 32'(tbl[i].exp_score));
      chk("tbl_alive", 32'(block_alive), 32'(tbl[i].exp_alive));
    end

    // Lose all lives
    for (int l = 2; l >= 0; l--) begin
      ball_lost = 1'b1;
      cycle();
      ball_lost = 1'b0;
      chk("lose_lives", 32'(lives), 32'(l));
      if (l > 0) begin
        chk("lose_serve", 32'(serve_rst), 32'd1);
        wait_play();
      end else begin
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_ball_en", 32'(ball_en), 32'd0);
      end
    end
    ball_lost = 1'b1;
    cycle();
    ball_lost = 1'b0;
    chk("over_ignore_lost", 32'(lives), 32'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("reload_lives", 32'(lives), 32'd3);
    chk("reload_score", 32'(score), 32'd0);
    chk("reload_alive", 32'(block_alive), 32'h7FFF);
    chk("reload_serve", 32'(serve_rst), 32'd1);
    chk("reload_over", 32'(game_over), 32'd0);
    wait_play();

    // Clear the field; POINTS=20 instance saturates
    collide = '1;
    cycle();
    collide = '0;
    repeat (15) cycle();
    chk("clear_score", 32'(score), 32'd150);
    chk("clear_sat", 32'(score2), 32'd255);
    chk("clear_win_early", 32'(win), 32'd0);
    cycle();
    chk("win_flag", 32'(win), 32'd1);
    chk("win_ball_en", 32'(ball_en), 32'd0);

    // Random play
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 24) == 0);
      ball_lost = ($urandom_range(0, 90) == 0);
      collide   = collide ^ N'($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b0;
        m_reset();
        #1;
        do_check();
        cycle();
        rst = 1'b1;
      end
      cycle();
    end

    // Reset mid-PLAY with pending hits
    start = 1'b0; ball_lost = 1'b0; collide = '0;
    rst = 1'b0;
    m_reset();
    #1;
    cycle();
    rst = 1'b1;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_play();
    collide = '1;
    cycle();
    cycle();
    chk("pre_rst_score", 32'(score), 32'd10);
    chk("pre_rst_alive", 32'(block_alive), 32'h7FFE);
    #2;
    rst = 1'b0;
    collide = '0;
    m_reset();
    #1;
    chk("async_score", 32'(score), 32'd0);
    chk("async_alive", 32'(block_alive), 32'h7FFF);
    chk("async_lives", 32'(lives), 32'd3);
    chk("async_ball_en", 32'(ball_en), 32'd0);
    chk("async_serve_rst", 32'(serve_rst), 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_play();
    repeat (5) cycle();
    chk("pend_cleared_score", 32'(score), 32'd0);
    chk("pend_cleared_alive", 32'(block_alive), 32'h7FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
